// File: rtl/line_sum_calculator.sv
// Multiplies a valid-qualified stream of pixel pairs and sums the products of
// each image line, emitting one line_sum per line and flagging the end of frame.
module line_sum_calculator #(
   parameter int unsigned LINE_SIZE    = 16,
   parameter int unsigned PIXEL_SIZE   = 8,
   parameter int unsigned NUM_OF_LINES = 8,
   localparam int unsigned SUM_W       = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE,
   localparam int unsigned LIDX_W      = $clog2(NUM_OF_LINES)
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic                  frame_start,
   input  logic                  pixel_valid,
   input  logic [PIXEL_SIZE-1:0] pixel_a,
   input  logic [PIXEL_SIZE-1:0] pixel_b,
   output logic [SUM_W-1:0]      line_sum,
   output logic                  line_sum_valid,
   output logic [LIDX_W-1:0]     line_idx,
   output logic                  frame_done,
   output logic                  pixel_drop
);

   localparam int unsigned PIX_W  = $clog2(LINE_SIZE);
   localparam int unsigned PROD_W = 2 * PIXEL_SIZE;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state;
   logic [PIX_W-1:0]    pix_cnt;
   logic [LIDX_W-1:0]   line_cnt;
   logic [PROD_W-1:0]   prod_r;
   logic                last_r;
   logic                p_valid;
   logic [LIDX_W-1:0]   line_r;
   logic [SUM_W-1:0]    acc;

   // frame_start makes the current pixel behave as pixel 0 of line 0
   logic [PIX_W-1:0]    cur_pix_c;
   logic [LIDX_W-1:0]   cur_line_c;
   logic                take_c;
   logic                cur_pix_last_c;
   logic                cur_line_last_c;
   logic [SUM_W-1:0]    sum_c;

   assign cur_pix_c       = frame_start ? '0 : pix_cnt;
   assign cur_line_c      = frame_start ? '0 : line_cnt;
   assign take_c          = pixel_valid && (frame_start || (state == RUN));
   assign cur_pix_last_c  = (cur_pix_c == PIX_W'(LINE_SIZE - 1));
   assign cur_line_last_c = (cur_line_c == LIDX_W'(NUM_OF_LINES - 1));
   assign sum_c           = acc + SUM_W'(prod_r);

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         pix_cnt        <= '0;
         line_cnt       <= '0;
         prod_r         <= '0;
         last_r         <= 1'b0;
         p_valid        <= 1'b0;
         line_r         <= '0;
         acc            <= '0;
         line_sum       <= '0;
         line_sum_valid <= 1'b0;
         line_idx       <= '0;
         frame_done     <= 1'b0;
         pixel_drop     <= 1'b0;
      end else begin
         line_sum_valid <= 1'b0;
         frame_done     <= 1'b0;
         pixel_drop     <= pixel_valid && !frame_start && (state != RUN);

         // stage 1: multiply and track position within line/frame
         p_valid <= take_c;
         if (take_c) begin
            prod_r <= PROD_W'(pixel_a) * PROD_W'(pixel_b);
            last_r <= cur_pix_last_c;
            line_r <= cur_line_c;
            if (cur_pix_last_c) begin
               pix_cnt  <= '0;
               line_cnt <= cur_line_last_c ? '0 : cur_line_c + LIDX_W'(1);
            end else begin
               pix_cnt  <= cur_pix_c + PIX_W'(1);
               line_cnt <= cur_line_c;
            end
         end else if (frame_start) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
         end

         // stage 2: accumulate; in-flight products are dropped on frame_start
         if (frame_start) begin
            acc <= '0;
         end else if (p_valid) begin
            if (last_r) begin
               line_sum       <= sum_c;
               line_sum_valid <= 1'b1;
               line_idx       <= line_r;
               frame_done     <= (line_r == LIDX_W'(NUM_OF_LINES - 1));
               acc            <= '0;
            end else begin
               acc <= sum_c;
            end
         end

         if (frame_start) begin
            state <= RUN;
         end else begin
            case (state)
               RUN:     if (take_c && cur_pix_last_c && cur_line_last_c) state <= DONE;
               default: state <= state;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_line_sum_calculator.sv
// Directed bench for line_sum_calculator with a scoreboard of expected line sums,
// indices, frame_done flags and output cycles.
module tb_line_sum_calculator;

   localparam int unsigned LINE_SIZE    = 16;
   localparam int unsigned PIXEL_SIZE   = 8;
   localparam int unsigned NUM_OF_LINES = 8;
   localparam int unsigned SUM_W        = 20;
   localparam int unsigned LIDX_W       = 3;

   logic                  CLK = 1'b0;
   logic                  reset = 1'b1;
   logic                  frame_start = 1'b0;
   logic                  pixel_valid = 1'b0;
   logic [PIXEL_SIZE-1:0] pixel_a = '0;
   logic [PIXEL_SIZE-1:0] pixel_b = '0;
   logic [SUM_W-1:0]      line_sum;
   logic                  line_sum_valid;
   logic [LIDX_W-1:0]     line_idx;
   logic                  frame_done;
   logic                  pixel_drop;

   line_sum_calculator #(
      .LINE_SIZE(LINE_SIZE), .PIXEL_SIZE(PIXEL_SIZE), .NUM_OF_LINES(NUM_OF_LINES)
   ) dut (
      .CLK(CLK), .reset(reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
      .pixel_a(pixel_a), .pixel_b(pixel_b), .line_sum(line_sum),
      .line_sum_valid(line_sum_valid), .line_idx(line_idx),
      .frame_done(frame_done), .pixel_drop(pixel_drop)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int unsigned sum;
      int unsigned idx;
      int unsigned fd;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   valid_cnt = 0;
   int   drop_cnt = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on every line_sum_valid pulse
   always @(negedge CLK) begin
      exp_t e;
      if (pixel_drop === 1'b1) drop_cnt++;
      if (frame_done === 1'b1) check("frame_done_with_valid", 32'(line_sum_valid), 32'd1);
      if (line_sum_valid === 1'b1) begin
         valid_cnt++;
         check("scoreboard_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("line_sum", 32'(line_sum), e.sum);
            check("line_idx", 32'(line_idx), e.idx);
            check("frame_done", 32'(frame_done), e.fd);
            check("latency_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic send(input int unsigned a, input int unsigned b);
      @(negedge CLK);
      frame_start = 1'b0;
      pixel_valid = 1'b1;
      pixel_a     = PIXEL_SIZE'(a);
      pixel_b     = PIXEL_SIZE'(b);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK);
         frame_start = 1'b0;
         pixel_valid = 1'b0;
      end
   endtask

   task automatic fs();
      @(negedge CLK);
      frame_start = 1'b1;
      pixel_valid = 1'b0;
   endtask

   // Called right after send() of a line's last pixel
   task automatic expect_line(input int unsigned sum, input int unsigned idx, input int unsigned fd);
      exp_t e;
      e.sum = sum; e.idx = idx; e.fd = fd; e.cyc = cyc + 2;
      sb.push_back(e);
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while (sb.size() != 0 && t < 20) begin
         @(negedge CLK);
         t++;
      end
      check(tag, sb.size(), 32'd0);
   endtask

   initial begin
      int v0, d0, sum2;
      #1 reset = 1'b0;
      #20;
      check("rst_line_sum", 32'(line_sum), 32'd0);
      check("rst_valid", 32'(line_sum_valid), 32'd0);
      check("rst_line_idx", 32'(line_idx), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_pixel_drop", 32'(pixel_drop), 32'd0);
      @(negedge CLK);
      reset = 1'b1;

      // 1: max-value line, back-to-back
      fs();
      for (int i = 0; i < 16; i++) send(255, 255);
      expect_line(1040400, 0, 0);
      idle(5);
      drain("t1_drain");
      check("t1_line_sum_held", 32'(line_sum), 32'd1040400);

      // 2: ramp with random gaps
      v0 = valid_cnt;
      sum2 = 0;
      for (int i = 0; i < 16; i++) begin
         idle(int'($urandom_range(0, 3)));
         send(i, 1);
         sum2 += i;
      end
      expect_line(32'(sum2), 1, 0);
      idle(5);
      drain("t2_drain");
      check("t2_single_valid", valid_cnt - v0, 32'd1);

      // 3: full frame
      fs();
      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < 16; i++) send(n + 1, 2);
         expect_line(32 * (n + 1), n, (n == 7) ? 1 : 0);
      end
      idle(5);
      drain("t3_drain");

      // 4: pixels in DONE are dropped
      v0 = valid_cnt;
      d0 = drop_cnt;
      for (int i = 0; i < 3; i++) send(7, 7);
      idle(4);
      check("t4_drop_count", drop_cnt - d0, 32'd3);
      check("t4_no_valid", valid_cnt - v0, 32'd0);

      // 5: restart mid-line discards partial sum
      v0 = valid_cnt;
      d0 = drop_cnt;
      fs();
      for (int i = 0; i < 10; i++) send(9, 9);
      fs();
      for (int i = 0; i < 16; i++) send(1, 1);
      expect_line(16, 0, 0);
      idle(5);
      drain("t5_drain");
      check("t5_single_valid", valid_cnt - v0, 32'd1);
      check("t5_no_drop", drop_cnt - d0, 32'd0);

      // 6: async reset mid-line
      fs();
      for (int i = 0; i < 5; i++) send(2, 2);
      @(negedge CLK);
      pixel_valid = 1'b0;
      #1 reset = 1'b0;
      #1;
      check("t6_async_line_sum", 32'(line_sum), 32'd0);
      check("t6_async_line_idx", 32'(line_idx), 32'd0);
      check("t6_async_valid", 32'(line_sum_valid), 32'd0);
      @(negedge CLK);
      #1 reset = 1'b1;
      v0 = valid_cnt;
      d0 = drop_cnt;
      send(4, 4);
      send(4, 4);
      idle(4);
      check("t6_drop_after_reset", drop_cnt - d0, 32'd2);
      check("t6_no_valid", valid_cnt - v0, 32'd0);
      fs();
      for (int i = 0; i < 16; i++) send(3, 5);
      expect_line(240, 0, 0);
      idle(5);
      drain("t6_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/line_sum_calculator.md
Name: line_sum_calculator

Overview:
Upstream stage of the line-sum accumulator. It consumes a valid-qualified stream of pixel pairs, multiplies each pair and sums the LINE_SIZE products of each image line. It emits one line_sum per line, with a valid pulse, which feeds the accumulator's line_sum input. A per-frame line counter marks the end of a frame after NUM_OF_LINES lines.

Parameters:
LINE_SIZE, 16, pixels per line (power of 2, >=2)
PIXEL_SIZE, 8, bits per pixel (unsigned)
NUM_OF_LINES, 8, lines per frame (>=2)
SUM_W (localparam), $clog2(LINE_SIZE)+2*PIXEL_SIZE, line_sum width; 20 at defaults

Ports:
CLK  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
frame_start  in  1  synchronous frame restart pulse
pixel_valid  in  1  pixel_a/pixel_b valid this cycle
pixel_a  in  PIXEL_SIZE  first operand pixel
pixel_b  in  PIXEL_SIZE  second operand pixel
line_sum  out  SUM_W  sum of a*b over last completed line, held until next line completes
line_sum_valid  out  1  one-cycle pulse when line_sum updates
line_idx  out  $clog2(NUM_OF_LINES)  index of line currently presented on line_sum
frame_done  out  1  one-cycle pulse coincident with line_sum_valid of line NUM_OF_LINES-1
pixel_drop  out  1  one-cycle pulse: pixel_valid seen while not in RUN

Behaviour:
- Reset (reset=0, async): all outputs 0; pixel count, line count, accumulator and pipeline registers 0; state IDLE.
- FSM states:
  - IDLE: wait for frame_start; go to RUN.
  - RUN: accept pixels; go to DONE when line NUM_OF_LINES-1 is completed at pipeline stage 1 (last pixel of last line sampled).
  - DONE: wait for frame_start; go to RUN.
- frame_start=1 in any state:
  - clears pixel count, line count and accumulator; flushes pipeline (in-flight products discarded, no line_sum_valid); enters RUN.
  - pixel_valid in the same cycle is accepted as pixel 0 of line 0.
  - line_sum and line_idx keep their last values.
- Pipeline stage 1 (edge k, RUN and pixel_valid=1):
  - prod_r <= pixel_a*pixel_b (2*PIXEL_SIZE bits).
  - last_r <= (pix_cnt==LINE_SIZE-1); p_valid <= 1.
  - pix_cnt wraps LINE_SIZE-1 -> 0, incrementing line count.
  - Without pixel_valid: p_valid <= 0, counters hold.
- Stage 2 (edge k+1, p_valid=1):
  - If last_r=0: acc <= acc + zero-extended prod_r.
  - If last_r=1: line_sum <= acc+prod_r; line_sum_valid <= 1; line_idx <= completed line number; acc <= 0.
  - frame_done <= 1 if that line is NUM_OF_LINES-1.
- Latency: line_sum_valid is high in the cycle after edge k+1, where k is the edge sampling the line's last pixel. This is a 2-cycle latency from last-pixel sample.
- Gaps in pixel_valid are allowed anywhere, including between lines; no back-pressure.
- Width: SUM_W never overflows (LINE_SIZE*(2^PIXEL_SIZE-1)^2 < 2^SUM_W); no saturation logic.
- pixel_valid in IDLE or DONE: pixel ignored, pixel_drop pulses next cycle. The last line still drains through stage 2 normally after entry to DONE.
- Reset asserted mid-line or mid-frame: partial sums lost immediately; block resumes in IDLE.

Test Plan:
1. Reset release; frame_start; 16 pixels a=255,b=255 back-to-back -> line_sum=1040400, line_sum_valid pulses exactly 2 cycles after the 16th pixel edge, line_idx=0.
2. Line with a=i,b=1 for i=0..15, random 0-3 cycle gaps between pixels -> line_sum=120, a single valid pulse; intermediate cycles show no valid.
3. Full frame of 8 lines, line n all pixels a=n+1,b=2 -> line_sums 32,64,...,256 with line_idx 0..7; frame_done only with the 256 result; then state DONE.
4. In DONE, drive 3 pixels without frame_start -> pixel_drop pulses 3 times, no line_sum_valid; frame_start then restarts at line_idx 0.
5. frame_start after 10 pixels of a line, then 16 pixels a=b=1 -> only one line_sum_valid with line_sum=16 (partial discarded).
6. reset=0 for 1 cycle mid-line (between clock edges) -> outputs 0 immediately and asynchronously; after release, pixels ignored with pixel_drop until frame_start.
